// File: rtl/apb_slave_mux_pkg.sv
// Shared definitions for the APB slave mux: bus width defines used by the
// upstream bridge, the FSM state encoding and a small sizing helper.
// Optional feature macro used by the top: APB_MUX_TIMEOUT_EN.

`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif

`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_slave_mux_pkg;

    // FSM state encoding, shared with anything that watches dbg_state.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        ERR_RESP = 2'd2,
        DRAIN    = 2'd3
    } mux_state_e;

    // Width of the slave index field; at least one bit even for one slave.
    function automatic int idx_width(input int num_slaves);
        return (num_slaves > 1) ? $clog2(num_slaves) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational APB address decoder: splits paddr into a slave index and
// flags addresses that fall outside the populated slave regions.

module apb_addr_decode
    import apb_slave_mux_pkg::*;
#(
    parameter int NUM_SLAVES      = 4,
    parameter int SLAVE_ADDR_BITS = 12,
    parameter int IDX_W           = idx_width(NUM_SLAVES)
) (
    input  logic [`PADDR_WIDTH-1:0] paddr,
    output logic [IDX_W-1:0]        idx,
    output logic                    unmapped
);

    // First address bit above the index field; anything set there is unmapped.
    localparam int HI_LSB = SLAVE_ADDR_BITS + IDX_W;
    localparam logic [IDX_W:0] SLV_CNT = (IDX_W + 1)'(NUM_SLAVES);

    logic hi_set;

    // Index extraction plus range check against the populated slave count.
    always_comb begin
        idx      = paddr[SLAVE_ADDR_BITS +: IDX_W];
        hi_set   = |(paddr >> HI_LSB);
        unmapped = hi_set | ({1'b0, idx} >= SLV_CNT);
    end

endmodule

// File: rtl/apb_slave_mux.sv
// APB decode/return stage behind the AHB-to-APB bridge. Latches the decoded
// slave for the whole transfer, drives a one-hot psel from that latched index
// and muxes the selected slave's response straight back (no added latency).
// Unmapped addresses get a local error response.
// Optional: define APB_MUX_TIMEOUT_EN to abort slaves that stall for
// TIMEOUT_CYCLES access-phase wait cycles.
//
// Handshake: the bridge holds psel_en for the whole transfer and raises
// penable for the access phase; a transfer completes in the cycle where
// pready_x is high, after which psel_en must fall before the next decode.

module apb_slave_mux
    import apb_slave_mux_pkg::*;
#(
    parameter int NUM_SLAVES      = 4,
    parameter int SLAVE_ADDR_BITS = 12,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                                  hclk,
    input  logic                                  hreset,
    input  logic                                  psel_en,
    input  logic                                  penable,
    input  logic [`PADDR_WIDTH-1:0]               paddr,
    output logic [NUM_SLAVES-1:0]                 psel,
    input  logic [NUM_SLAVES-1:0]                 pready_s,
    input  logic [NUM_SLAVES-1:0]                 pslverr_s,
    input  logic [NUM_SLAVES*`APB_DATA_WIDTH-1:0] prdata_s,
    output logic                                  pready_x,
    output logic                                  pslverr_x,
    output logic [`APB_DATA_WIDTH-1:0]            prdata_x,
    output logic                                  err_pulse,
    output logic [`PADDR_WIDTH-1:0]               err_addr,
    output logic [1:0]                            dbg_state
);

    localparam int IDX_W = idx_width(NUM_SLAVES);
    localparam int DW    = `APB_DATA_WIDTH;

    // A non-positive timeout has no meaning; stop elaboration early.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_slave_mux: TIMEOUT_CYCLES must be at least 1");
    end

    mux_state_e               state_q, state_d;
    logic [IDX_W-1:0]         cur_idx_q, cur_idx_d;
    logic [`PADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
    logic [`PADDR_WIDTH-1:0]  err_addr_q, err_addr_d;

`ifdef APB_MUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]         cnt_q, cnt_d;
`endif

    logic [IDX_W-1:0]         dec_idx;
    logic                     dec_unmapped;
    logic                     sel_ready;
    logic                     sel_err;
    logic [DW-1:0]            sel_data;

    apb_addr_decode #(
        .NUM_SLAVES      (NUM_SLAVES),
        .SLAVE_ADDR_BITS (SLAVE_ADDR_BITS),
        .IDX_W           (IDX_W)
    ) u_decode (
        .paddr    (paddr),
        .idx      (dec_idx),
        .unmapped (dec_unmapped)
    );

    // Pick the latched slave's response lines; never driven from live paddr.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (cur_idx_q == IDX_W'(i)) begin
                sel_ready = pready_s[i];
                sel_err   = pslverr_s[i];
                sel_data  = prdata_s[i*DW +: DW];
            end
        end
    end

    // Next-state, latch updates and the combinational return path.
    always_comb begin
        state_d    = state_q;
        cur_idx_d  = cur_idx_q;
        cur_addr_d = cur_addr_q;
        err_addr_d = err_addr_q;
`ifdef APB_MUX_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        psel       = '0;
        pready_x   = 1'b0;
        pslverr_x  = 1'b0;
        prdata_x   = '0;
        err_pulse  = 1'b0;

        case (state_q)
            IDLE: begin
                // penable may already be high here; it does not matter.
                if (psel_en) begin
                    cur_idx_d  = dec_idx;
                    cur_addr_d = paddr;
                    state_d    = dec_unmapped ? ERR_RESP : ACTIVE;
`ifdef APB_MUX_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end

            ACTIVE: begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    psel[i] = psel_en && (cur_idx_q == IDX_W'(i));
                end
                prdata_x  = sel_data;
                pready_x  = penable & sel_ready;
                pslverr_x = penable & sel_ready & sel_err;
                if (pready_x) begin
                    state_d = DRAIN;
                end else if (!psel_en) begin
                    state_d = IDLE;
`ifdef APB_MUX_TIMEOUT_EN
                end else if (penable) begin
                    // This cycle is a wait cycle; abort once the budget is spent.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ERR_RESP;
                    end
`endif
                end
            end

            ERR_RESP: begin
                pready_x  = penable;
                pslverr_x = penable;
                err_pulse = penable;
                if (penable) begin
                    err_addr_d = cur_addr_q;
                    state_d    = DRAIN;
                end else if (!psel_en) begin
                    state_d = IDLE;
                end
            end

            DRAIN: begin
                // Hold off until the bridge releases psel_en, so every new
                // transfer is decoded fresh from IDLE.
                if (!psel_en) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and latch registers, cleared asynchronously.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q    <= IDLE;
            cur_idx_q  <= '0;
            cur_addr_q <= '0;
            err_addr_q <= '0;
`ifdef APB_MUX_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cur_idx_q  <= cur_idx_d;
            cur_addr_q <= cur_addr_d;
            err_addr_q <= err_addr_d;
`ifdef APB_MUX_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign err_addr  = err_addr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_slave_mux.sv
// Self-checking bench for apb_slave_mux (4 slaves, 4 KiB regions, 32-bit bus).
// The reference model works at transaction level: a transfer to address A
// targets slave A/4096 when that quotient is below 4, otherwise it is an
// error, and each phase of the transfer has a fixed expected response.

module tb_apb_slave_mux;

    localparam int NS = 4;

    logic          hclk;
    logic          hreset;
    logic          psel_en;
    logic          penable;
    logic [31:0]   paddr;
    logic [NS-1:0] psel;
    logic [NS-1:0] pready_s;
    logic [NS-1:0] pslverr_s;
    logic [NS*32-1:0] prdata_s;
    logic          pready_x;
    logic          pslverr_x;
    logic [31:0]   prdata_x;
    logic          err_pulse;
    logic [31:0]   err_addr;
    logic [1:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_err = 32'h0;

    apb_slave_mux #(
        .NUM_SLAVES      (NS),
        .SLAVE_ADDR_BITS (12),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .psel_en   (psel_en),
        .penable   (penable),
        .paddr     (paddr),
        .psel      (psel),
        .pready_s  (pready_s),
        .pslverr_s (pslverr_s),
        .prdata_s  (prdata_s),
        .pready_x  (pready_x),
        .pslverr_x (pslverr_x),
        .prdata_x  (prdata_x),
        .err_pulse (err_pulse),
        .err_addr  (err_addr),
        .dbg_state (dbg_state)
    );

    // Clock
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge hclk);
        #1;
    endtask

    task automatic settle();
        @(negedge hclk);
    endtask

    // Slaves chatter on all their response lines; only the selected one matters.
    task automatic noise();
        pready_s  = NS'($urandom);
        pslverr_s = NS'($urandom);
        for (int i = 0; i < NS; i++) prdata_s[i*32 +: 32] = $urandom;
    endtask

    // Expected quiet outputs outside any active response.
    task automatic check_quiet(input string tag);
        check_eq({tag, ".psel"},     32'(psel),      32'h0);
        check_eq({tag, ".pready"},   32'(pready_x),  32'h0);
        check_eq({tag, ".pslverr"},  32'(pslverr_x), 32'h0);
        check_eq({tag, ".prdata"},   prdata_x,       32'h0);
        check_eq({tag, ".errpulse"}, 32'(err_pulse), 32'h0);
        check_eq({tag, ".erraddr"},  err_addr,       last_err);
    endtask

    // One complete bridge transfer: setup, access (with waits), optional
    // extra cycles holding psel_en, then a release cycle.
    task automatic run_xfer(input logic [31:0] addr, input int waits, input bit early,
                            input int hold, input bit serr, input bit use_fd,
                            input logic [31:0] fd);
        int  idx;
        bit  mapped;
        idx    = int'(addr >> 12);
        mapped = (addr >> 12) < NS;

        psel_en = 1'b1; penable = early; paddr = addr; noise();
        settle();
        check_quiet("setup");
        next_cycle();

        if (mapped) begin
            for (int w = 0; w <= waits; w++) begin
                penable = 1'b1; noise();
                pready_s[idx] = (w == waits);
                if (w == waits) begin
                    pslverr_s[idx] = serr;
                    if (use_fd) prdata_s[idx*32 +: 32] = fd;
                end
                settle();
                check_eq("acc.psel",     32'(psel),      32'h1 << idx);
                check_eq("acc.pready",   32'(pready_x),  32'(w == waits));
                check_eq("acc.pslverr",  32'(pslverr_x), 32'((w == waits) && serr));
                check_eq("acc.prdata",   prdata_x,       prdata_s[idx*32 +: 32]);
                check_eq("acc.errpulse", 32'(err_pulse), 32'h0);
                next_cycle();
            end
        end else begin
            penable = 1'b1; noise();
            settle();
            check_eq("err.psel",     32'(psel),      32'h0);
            check_eq("err.pready",   32'(pready_x),  32'h1);
            check_eq("err.pslverr",  32'(pslverr_x), 32'h1);
            check_eq("err.prdata",   prdata_x,       32'h0);
            check_eq("err.errpulse", 32'(err_pulse), 32'h1);
            next_cycle();
            last_err = addr;
        end

        for (int h = 0; h < hold; h++) begin
            psel_en = 1'b1; penable = 1'b0; paddr = $urandom; noise();
            settle();
            check_quiet("drain");
            next_cycle();
        end

        psel_en = 1'b0; penable = 1'b0; paddr = $urandom; noise();
        settle();
        check_quiet("release");
        next_cycle();
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return (32'($urandom_range(0, 3)) << 12) | 32'($urandom_range(0, 4095));
        if (r == 7) return (32'($urandom_range(4, 15)) << 12) | 32'($urandom_range(0, 4095));
        return $urandom | 32'h0001_0000;
    endfunction

    initial begin
        hreset = 1'b1; psel_en = 1'b0; penable = 1'b0; paddr = '0;
        pready_s = '0; pslverr_s = '0; prdata_s = '0;

        // Reset state
        settle();
        check_quiet("reset");
        check_eq("reset.state", 32'(dbg_state), 32'h0);
        next_cycle();
        hreset = 1'b0;
        next_cycle();

        // Directed cases
        run_xfer(32'h0000_1004, 0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
        run_xfer(32'h0000_3010, 3, 1'b0, 0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        run_xfer(32'h0000_5000, 0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
        run_xfer(32'h0000_0008, 1, 1'b0, 1, 1'b1, 1'b0, 32'h0);
        run_xfer(32'h0000_1000, 0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
        run_xfer(32'h0000_2ffc, 2, 1'b1, 2, 1'b0, 1'b0, 32'h0);
        run_xfer(32'h8000_0000, 0, 1'b1, 1, 1'b0, 1'b0, 32'h0);

`ifdef APB_MUX_TIMEOUT_EN
        // Slave 2 never answers: 8 wait cycles, then a local error.
        psel_en = 1'b1; penable = 1'b0; paddr = 32'h0000_2000; noise();
        settle(); next_cycle();
        for (int w = 0; w < 8; w++) begin
            penable = 1'b1; noise(); pready_s[2] = 1'b0;
            settle();
            check_eq("to.psel",   32'(psel),     32'h4);
            check_eq("to.pready", 32'(pready_x), 32'h0);
            next_cycle();
        end
        noise(); pready_s[2] = 1'b0;
        settle();
        check_eq("to.psel_drop", 32'(psel),      32'h0);
        check_eq("to.pready",    32'(pready_x),  32'h1);
        check_eq("to.pslverr",   32'(pslverr_x), 32'h1);
        check_eq("to.errpulse",  32'(err_pulse), 32'h1);
        next_cycle();
        last_err = 32'h0000_2000;
        psel_en = 1'b0; penable = 1'b0; noise();
        settle(); check_quiet("to.release"); next_cycle();
`endif

        // Randomized transfers
        for (int t = 0; t < 40; t++) begin
            run_xfer(rand_addr(), $urandom_range(0, 4), ($urandom_range(0, 3) == 0),
                     $urandom_range(0, 2), 1'($urandom), 1'b0, 32'h0);
        end

        // Reset in the middle of a waiting access phase
        psel_en = 1'b1; penable = 1'b0; paddr = 32'h0000_2040; noise();
        settle(); next_cycle();
        penable = 1'b1; noise(); pready_s[2] = 1'b0;
        settle();
        check_eq("rst.pre_psel", 32'(psel), 32'h4);
        #1;
        hreset = 1'b1; pready_s = '1;
        #1;
        last_err = 32'h0;
        check_quiet("rst.mid");
        psel_en = 1'b0; penable = 1'b0;
        next_cycle();
        hreset = 1'b0;
        next_cycle();
        penable = 1'b1; pready_s = '1; pslverr_s = '1;
        settle();
        check_quiet("rst.late_ready");
        next_cycle();
        penable = 1'b0;

        // Recovery after reset
        run_xfer(32'h0000_3000, 1, 1'b0, 0, 1'b1, 1'b1, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
